cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
Shares one branch/compare evaluator between two requesters: port 0 is branch resolution and port 1 is the slt/sltu path. It arbitrates round-robin, latches the operands and evaluates the registered compare. It then holds the result on a valid/ready response channel until it is consumed. It sits between the control/decode logic and the datapath, and replaces ad-hoc sharing of the comparator through cmpmux.

Parameters:
WIDTH, 32, operand width in bits (rv32i_word when 32)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous abort of any in-flight compare
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept, one-hot or zero
req_cmpop0  input  3  branch_funct3_t for requester 0
req_a0  input  WIDTH  requester 0 left operand (rs1)
req_b0  input  WIDTH  requester 0 right operand (rs2 or imm)
req_cmpop1  input  3  branch_funct3_t for requester 1
req_a1  input  WIDTH  requester 1 left operand
req_b1  input  WIDTH  requester 1 right operand
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_id  output  1  requester that owns the result
resp_br_en  output  1  compare outcome
resp_err  output  1  cmpop was an illegal encoding
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. rst has priority over flush, and flush has priority over everything else.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), resp_valid=0, resp_id=0, resp_br_en=0, resp_err=0, busy=0. req_ready=0 while rst=1.
- States: IDLE, EVAL, DONE.
- IDLE, grant selection (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
- IDLE, accept:
  - req_ready[g] = grant & ~flush & ~rst.
  - On a transfer (req_valid[g] & req_ready[g]): latch cmpop/a/b and id=g, set last_grant=g, go to EVAL.
- EVAL:
  - Evaluate from the latched operands only.
  - cmd = cmpop.
  - eq = (a==b); lt = signed(a)<signed(b); ltu = a<b.
  - base = eq for cmd[2:1]=00, lt for 10, ltu for 11.
  - br_en = base ^ cmd[0].
  - cmd[2:1]=01 (funct3 010/011) is illegal: br_en=0, err=1.
  - Register resp_br_en, resp_err and resp_id, then go to DONE.
- DONE:
  - resp_valid=1 and all resp_* stay stable until resp_valid & resp_ready.
  - On the handshake go to IDLE. The next accept happens in IDLE, so minimum spacing is 3 cycles per compare.
- Latency: accept at cycle N gives resp_valid=1 at cycle N+2. If resp_ready=1 that cycle, busy drops at N+3.
- req_ready is 0 in EVAL and DONE. Requesters hold valid and payload stable until accepted. The arbiter does not sample unaccepted payload.
- flush in EVAL or DONE: go to IDLE next cycle, resp_valid=0 next cycle, result dropped, last_grant kept.
- flush in IDLE: no accept that cycle.
- rst at any point: all outputs return to reset values on the next edge and any in-flight result is lost.
- resp_ready while resp_valid=0 is ignored.
- No combinational path from req_* to resp_*. The only combinational input-to-output path is req_valid/flush/rst to req_ready.

Decomposition:
- rv32i_types gains:
  - cmp_arb_state_t, an enum {IDLE, EVAL, DONE}.
  - cmp_req_id_t, 1 bit.
  - Constant CMP_SEL_ILLEGAL = 2'b01.
- branch_funct3_t is reused as-is.
- One sub-module, rr_arb2: 2-way round-robin grant from req_valid and last_grant, producing a one-hot grant.
- The compare stays inline in EVAL.

Test Plan:
- Requester 0 only, cmpop=beq, a=5, b=5 -> req_ready[0]=1 same cycle; resp_valid at +2; resp_br_en=1, resp_id=0, resp_err=0.
- Requester 1, blt then bltu, a=0xFFFFFFFF, b=0x00000001 -> resp_br_en=1 then 0; bge a=b=0x80000000 -> 1; bne a=3, b=4 -> 1.
- Both valid continuously after reset, four compares -> grants 0,1,0,1; req_ready never two-hot; each payload matches its resp_id.
- Accepted compare, resp_ready held 0 for 5 cycles -> resp_valid and resp_* stable all 5 cycles, req_ready=0, busy=1; resp_ready=1 -> IDLE next cycle.
- cmpop=3'b010, a=b=0 -> resp_err=1, resp_br_en=0; a following beq a=b=0 -> resp_err=0, resp_br_en=1.
- flush in EVAL -> no resp_valid ever for that request, IDLE next cycle; rst while in DONE -> resp_valid=0, busy=0 next cycle; requester 0 wins the next tie.

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cmp_arbiter_pkg
// Shared types for the branch/compare arbiter:
//   branch_funct3_t  - RV32I branch funct3 encodings (reused by requesters)
//   cmp_arb_state_t  - arbiter FSM states
//   cmp_req_id_t     - requester index (0 = branch resolution, 1 = slt/sltu)
//   CMP_SEL_*        - compare selector values taken from funct3[2:1]
// -----------------------------------------------------------------------------
package cmp_arbiter_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } cmp_arb_state_t;

    typedef logic cmp_req_id_t;

    // funct3[2:1] selects the base relation; funct3[0] inverts it.
    localparam logic [1:0] CMP_SEL_EQ      = 2'b00;
    localparam logic [1:0] CMP_SEL_ILLEGAL = 2'b01;
    localparam logic [1:0] CMP_SEL_LT      = 2'b10;
    localparam logic [1:0] CMP_SEL_LTU     = 2'b11;

endpackage : cmp_arbiter_pkg

// File: rtl/cmp_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. Purely combinational.
// Ports:
//   req_valid  [1:0] in   per-requester request
//   last_grant       in   requester granted most recently
//   grant      [1:0] out  one-hot grant, zero when nobody requests
// A lone requester always wins; on a tie the one that did not win last time
// is granted.
// -----------------------------------------------------------------------------
module rr_arb2
    import cmp_arbiter_pkg::*;
(
    input  logic [1:0]  req_valid,
    input  cmp_req_id_t last_grant,
    output logic [1:0]  grant
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        localparam cmp_req_id_t MY_ID = cmp_req_id_t'(gi);
        assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (last_grant != MY_ID));
    end

endmodule : rr_arb2

// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
// Shares one registered branch/compare evaluator between two requesters
// (0 = branch resolution, 1 = slt/sltu). Round-robin accept in IDLE, compare
// of the latched operands in EVAL, result held on a valid/ready channel in
// DONE.
// Ports:
//   clk, rst (sync, active-high), flush (aborts in-flight compare)
//   req_valid[1:0] / req_ready[1:0]       request handshake, ready one-hot or 0
//   req_cmpop0/a0/b0, req_cmpop1/a1/b1    per-requester funct3 and operands
//   resp_valid / resp_ready               response handshake
//   resp_id, resp_br_en, resp_err         result owner, outcome, illegal funct3
//   busy                                  FSM not in IDLE
// All resp_* outputs come straight from flops; the only combinational
// input-to-output path is req_valid/flush/rst -> req_ready.
// -----------------------------------------------------------------------------
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_cmpop0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_cmpop1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_br_en,
    output logic             resp_err,
    output logic             busy
);

    cmp_arb_state_t   state_q, state_d;
    cmp_req_id_t      last_grant_q, last_grant_d;
    cmp_req_id_t      id_q, id_d;
    logic [2:0]       cmpop_q, cmpop_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_req_id_t      resp_id_q, resp_id_d;
    logic             resp_br_en_q, resp_br_en_d;
    logic             resp_err_q, resp_err_d;

    logic [1:0]       grant;
    cmp_req_id_t      grant_id;
    logic             accept;
    logic             cmp_eq, cmp_lt, cmp_ltu;
    logic             cmp_base, cmp_br_en, cmp_err;

    rr_arb2 u_rr_arb2 (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // grant is one-hot or zero, so bit 1 alone identifies the winner.
    assign grant_id  = cmp_req_id_t'(grant[1]);
    assign req_ready = (state_q == IDLE && !flush && !rst) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);

    // Compare works only on the latched operands, never on live request ports.
    always_comb begin
        cmp_eq    = (a_q == b_q);
        cmp_lt    = ($signed(a_q) < $signed(b_q));
        cmp_ltu   = (a_q < b_q);
        cmp_base  = 1'b0;
        cmp_err   = 1'b0;
        case (cmpop_q[2:1])
            CMP_SEL_EQ:      cmp_base = cmp_eq;
            CMP_SEL_LT:      cmp_base = cmp_lt;
            CMP_SEL_LTU:     cmp_base = cmp_ltu;
            CMP_SEL_ILLEGAL: cmp_err  = 1'b1;
            default:         cmp_err  = 1'b1;
        endcase
        cmp_br_en = cmp_err ? 1'b0 : (cmp_base ^ cmpop_q[0]);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cmpop_d      = cmpop_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_id_d    = resp_id_q;
        resp_br_en_d = resp_br_en_q;
        resp_err_d   = resp_err_q;

        if (flush) begin
            // Drop whatever is in flight; last_grant keeps its history.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmpop_d      = grant_id ? req_cmpop1 : req_cmpop0;
                        a_d          = grant_id ? req_a1 : req_a0;
                        b_d          = grant_id ? req_b1 : req_b0;
                        id_d         = grant_id;
                        last_grant_d = grant_id;
                        state_d      = EVAL;
                    end
                end
                EVAL: begin
                    resp_br_en_d = cmp_br_en;
                    resp_err_d   = cmp_err;
                    resp_id_d    = id_q;
                    state_d      = DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= cmp_req_id_t'(1'b1);
            id_q         <= cmp_req_id_t'(1'b0);
            cmpop_q      <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            resp_id_q    <= cmp_req_id_t'(1'b0);
            resp_br_en_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cmpop_q      <= cmpop_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_id_q    <= resp_id_d;
            resp_br_en_q <= resp_br_en_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_id    = resp_id_q;
    assign resp_br_en = resp_br_en_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule : cmp_arbiter

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_cmpop0, req_cmpop1;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
    logic             resp_valid, resp_ready, resp_id, resp_br_en, resp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmpop0 (req_cmpop0),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_cmpop1 (req_cmpop1),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_br_en (resp_br_en),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        flush = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req_cmpop0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_cmpop1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[r] = 1'b1;
    endtask

    // Drives one request to completion; checks are done by callers.
    task automatic run_cmp(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic br, output logic err, output logic id, output bit ok);
        bit got;
        ok = 0; got = 0; br = 1'bx; err = 1'bx; id = 1'bx;
        set_req(r, op, a, b);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready[r]) begin got = 1; break; end
            tick();
        end
        if (got) begin
            tick();
            req_valid[r] = 1'b0;
            got = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (resp_valid) begin
                    got = 1; br = resp_br_en; err = resp_err; id = resp_id;
                    break;
                end
                tick();
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            ok = got;
        end else begin
            req_valid[r] = 1'b0;
        end
        $display("txn req=%0d op=%03b a=%08h b=%08h -> done=%0d id=%0d br_en=%0d err=%0d",
                 r, op, a, b, ok, id, br, err);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; resp_ready = 1'b0; req_valid = 2'b11;
        req_cmpop0 = BEQ; req_a0 = '0; req_b0 = '0;
        req_cmpop1 = BEQ; req_a1 = '0; req_b1 = '0;
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        checks++;
        if ({resp_valid, busy, resp_id, resp_br_en, resp_err} !== 5'b00000) begin
            errors++; $display("FAIL reset_outputs: got v%b busy%b id%b br%b err%b want all 0",
                               resp_valid, busy, resp_id, resp_br_en, resp_err);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beq();
        set_req(0, BEQ, 32'd5, 32'd5);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL beq_ready: got %b want 01", req_ready);
        end
        tick();                     // accepted at this edge (cycle N)
        req_valid = 2'b00;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL beq_n1: got resp_valid %b busy %b want 0 1", resp_valid, busy);
        end
        tick();
        #1;
        checks++;
        if ({resp_valid, resp_br_en, resp_id, resp_err} !== 4'b1100) begin
            errors++; $display("FAIL beq_resp: got v%b br%b id%b err%b want 1 1 0 0",
                               resp_valid, resp_br_en, resp_id, resp_err);
        end
        $display("txn req=0 op=000 a=5 b=5 -> id=%0d br_en=%0d err=%0d", resp_id, resp_br_en, resp_err);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL beq_release: got busy %b resp_valid %b want 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_req1_ops();
        logic [2:0]  ops [4]  = '{BLT, BLTU, BGE, BNE};
        logic [31:0] as  [4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
        logic [31:0] bs  [4]  = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'd4};
        logic        exp [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic br, err, id;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            run_cmp(1, ops[k], as[k], bs[k], br, err, id, ok);
            checks++;
            if (!ok || br !== exp[k] || err !== 1'b0 || id !== 1'b1) begin
                errors++; $display("FAIL req1_op%0d: got done%0d br%b err%b id%b want 1 %b 0 1",
                                   k, ok, br, err, id, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit two_hot, rdy_bad, got;
        logic [1:0] exp_rdy;
        do_reset();
        two_hot = 0; rdy_bad = 0;
        // requester 0 result is 1, requester 1 result is 0: payload follows resp_id
        set_req(0, BEQ, 32'd7, 32'd7);
        set_req(1, BNE, 32'd7, 32'd7);
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            got = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (req_ready == 2'b11) two_hot = 1;
                if (req_ready != 2'b00) begin got = 1; break; end
                tick();
            end
            checks++;
            if (!got || req_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, exp_rdy);
            end
            tick();
            got = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (req_ready != 2'b00) rdy_bad = 1;
                if (resp_valid) begin got = 1; break; end
                tick();
            end
            checks++;
            if (!got || resp_id !== exp_rdy[1] || resp_br_en !== exp_rdy[0]) begin
                errors++; $display("FAIL b2b_resp%0d: got v%b id%b br%b want 1 %b %b",
                                   k, got, resp_id, resp_br_en, exp_rdy[1], exp_rdy[0]);
            end
            $display("txn b2b k=%0d id=%0d br_en=%0d", k, resp_id, resp_br_en);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        req_valid = 2'b00;
        checks++;
        if (two_hot || rdy_bad) begin
            errors++; $display("FAIL b2b_ready_rules: got two_hot %0d ready_while_busy %0d want 0 0",
                               two_hot, rdy_bad);
        end
        tick();
    endtask

    task automatic test_stall();
        bit bad;
        set_req(0, BLT, 32'd1, 32'd2);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL stall_accept: got %b want 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        set_req(1, BEQ, 32'd0, 32'd0);   // waiting requester must not be readied
        tick();                           // now in DONE
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({resp_valid, resp_br_en, resp_id, resp_err, busy} !== 5'b11001 || req_ready !== 2'b00)
                bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL stall_hold: got v%b br%b id%b err%b busy%b rdy%b want 1 1 0 0 1 00",
                               resp_valid, resp_br_en, resp_id, resp_err, busy, req_ready);
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got busy %b v %b want 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_illegal();
        logic br, err, id;
        bit ok;
        run_cmp(0, 3'b010, 32'd0, 32'd0, br, err, id, ok);
        checks++;
        if (!ok || err !== 1'b1 || br !== 1'b0) begin
            errors++; $display("FAIL illegal_op: got done%0d err%b br%b want 1 1 0", ok, err, br);
        end
        run_cmp(0, BEQ, 32'd0, 32'd0, br, err, id, ok);
        checks++;
        if (!ok || err !== 1'b0 || br !== 1'b1) begin
            errors++; $display("FAIL illegal_recover: got done%0d err%b br%b want 1 0 1", ok, err, br);
        end
    endtask

    task automatic test_flush();
        bit seen;
        set_req(1, BLT, 32'd1, 32'd2);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL flush_accept: got %b want 10", req_ready);
        end
        tick();                          // in EVAL
        req_valid = 2'b00;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL flush_eval: got busy %b v %b want 0 0", busy, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL flush_no_resp: got resp_valid after flush want none");
        end
        set_req(0, BEQ, 32'd1, 32'd1);
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL flush_idle_ready: got %b want 00", req_ready);
        end
        tick();
        flush = 1'b0;
        req_valid = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept: got busy %b want 0", busy);
        end
        tick();
    endtask

    task automatic test_rst_done();
        set_req(0, BEQ, 32'd9, 32'd9);   // last_grant becomes 0
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_br_en !== 1'b1) begin
            errors++; $display("FAIL rst_pre_done: got v %b br %b want 1 1", resp_valid, resp_br_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({resp_valid, busy, resp_br_en, resp_id, resp_err} !== 5'b00000) begin
            errors++; $display("FAIL rst_done: got v%b busy%b br%b id%b err%b want all 0",
                               resp_valid, busy, resp_br_en, resp_id, resp_err);
        end
        set_req(0, BEQ, 32'd0, 32'd0);
        set_req(1, BEQ, 32'd0, 32'd0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_tie: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_beq();
        test_req1_ops();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_flush();
        test_rst_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cmp_arbiter
